// File: rtl/ripple_carry_adder_8bit_pkg.sv
// Shared constants for the ripple-carry adder slice.
package ripple_carry_adder_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/ripple_carry_adder_8bit_full_adder.sv
// Single-bit full adder: one stage of the ripple carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    // Carry is generated by a&b or propagated from cin when exactly one input is set.
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/ripple_carry_adder_8bit.sv
// Unsigned WIDTH-bit ripple-carry adder with a combinational sum and a
// one-cycle registered copy that clears asynchronously on reset.
module ripple_carry_adder_8bit
    import ripple_carry_adder_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic [WIDTH-1:0] out_q,
    output logic             carry_out_q
);

    // carry[i] feeds stage i; carry[WIDTH] leaves the MSB stage.
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (carry[i]),
            .sum  (out[i]),
            .cout (carry[i+1])
        );
    end

    assign carry_out = carry[WIDTH];

    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // which is what makes an operand change coincident with the edge land next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            out_q       <= out;
            carry_out_q <= carry_out;
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder_8bit.sv
// Scoreboard bench for ripple_carry_adder_8bit: stimulus pushes expected sums,
// a negedge monitor checks the combinational and the registered outputs.
module tb_ripple_carry_adder_8bit;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in1 = '0;
    logic [7:0] in2 = '0;
    logic [7:0] out;
    logic       carry_out;
    logic [7:0] out_q;
    logic       carry_out_q;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t comb_q[$];
    vec_t pend;
    logic pend_valid = 1'b0;

    ripple_carry_adder_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in1         (in1),
        .in2         (in2),
        .out         (out),
        .carry_out   (carry_out),
        .out_q       (out_q),
        .carry_out_q (carry_out_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic c);
        vec_t v;
        @(posedge clk);
        #1;
        in1 = a;
        in2 = b;
        v.a = a; v.b = b; v.sum = s; v.c = c;
        comb_q.push_back(v);
    endtask

    // Monitor: comb result for the vector applied this cycle, registered
    // result for the vector applied the cycle before.
    initial begin
        vec_t v;
        forever begin
            @(negedge clk);
            if (pend_valid) begin
                check($sformatf("out_q %02h+%02h", pend.a, pend.b), {24'd0, out_q}, {24'd0, pend.sum});
                check($sformatf("carry_out_q %02h+%02h", pend.a, pend.b), {31'd0, carry_out_q}, {31'd0, pend.c});
            end
            if (comb_q.size() > 0) begin
                v = comb_q.pop_front();
                check($sformatf("out %02h+%02h", v.a, v.b), {24'd0, out}, {24'd0, v.sum});
                check($sformatf("carry_out %02h+%02h", v.a, v.b), {31'd0, carry_out}, {31'd0, v.c});
                pend       = v;
                pend_valid = 1'b1;
            end else begin
                pend_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra, rb;
        logic [8:0] ref_sum;
        bit         drained;

        // Reset: registered outputs clear at once, comb path keeps tracking.
        #2 rst_n = 1'b0;
        #1;
        check("reset out_q", {24'd0, out_q}, 32'h0);
        check("reset carry_out_q", {31'd0, carry_out_q}, 32'h0);
        check("reset out 0+0", {24'd0, out}, 32'h0);
        in1 = 8'h03; in2 = 8'h04;
        #1;
        check("reset out 3+4", {24'd0, out}, 32'h07);
        @(posedge clk); #1;
        check("reset holds out_q", {24'd0, out_q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        apply(8'h00, 8'h00, 8'h00, 1'b0);
        apply(8'hFF, 8'h01, 8'h00, 1'b1);
        apply(8'h0F, 8'hF0, 8'hFF, 1'b0);
        apply(8'h7F, 8'h7F, 8'hFE, 1'b0);
        apply(8'h80, 8'h80, 8'h00, 1'b1);
        apply(8'hFF, 8'hFF, 8'hFE, 1'b1);
        apply(8'h12, 8'h34, 8'h46, 1'b0);
        apply(8'hC8, 8'h64, 8'h2C, 1'b1);

        // Doubling sweep: 2k mod 256, carry set from k=128 upward.
        for (int k = 1; k < 256; k++) begin
            ra = 8'(k);
            apply(ra, ra, 8'((2 * k) % 256), (k >= 128));
        end

        for (int i = 0; i < 1000; i++) begin
            ra      = 8'($urandom_range(0, 255));
            rb      = 8'($urandom_range(0, 255));
            ref_sum = {1'b0, ra} + {1'b0, rb};
            apply(ra, rb, ref_sum[7:0], ref_sum[8]);
        end

        drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            @(posedge clk);
            if (comb_q.size() == 0 && !pend_valid) drained = 1'b1;
        end
        check("scoreboard drained", {31'd0, drained}, 32'h1);

        // Registered path, mid-cycle reset, reload after release.
        @(posedge clk); #1;
        in1 = 8'hAA; in2 = 8'h55;
        #1;
        check("out AA+55", {24'd0, out}, 32'hFF);
        @(posedge clk); #1;
        check("out_q AA+55", {24'd0, out_q}, 32'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset out_q", {24'd0, out_q}, 32'h0);
        check("mid reset carry_out_q", {31'd0, carry_out_q}, 32'h0);
        check("mid reset out", {24'd0, out}, 32'hFF);
        @(posedge clk); #1;
        check("reset across edge out_q", {24'd0, out_q}, 32'h0);
        in2 = 8'h56;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("released before edge out_q", {24'd0, out_q}, 32'h0);
        @(posedge clk); #1;
        check("reload out_q", {24'd0, out_q}, 32'h00);
        check("reload carry_out_q", {31'd0, carry_out_q}, 32'h1);
        check("reload carry_out", {31'd0, carry_out}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
